// File: rtl/imem_loader.sv
// imem_loader: assembles a big-endian byte stream into 32-bit instruction
// words and writes them to the instruction RAM at sequential addresses,
// holding the CPU in reset while a program is loaded.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   defined   -> checksum accumulates the XOR of every written word
//   undefined -> checksum is tied to zero
//
// Ports:
//   clk           system clock, all state on rising edge
//   reset         asynchronous, active-high reset
//   start         one-cycle pulse, begins a load of n_words words
//   n_words       word count latched on start (0 = no load, >2**AW clamps)
//   in_data       stream byte, MSB byte of each word first
//   in_valid      in_data valid
//   in_ready      loader accepts a byte this cycle
//   we/wa/wd      instruction RAM write port (we pulses once per word)
//   cpu_hold      high while a load is in progress
//   done          load finished, sticky until next start or reset
//   words_written words written in the current/last load
//   checksum      XOR of all written words (see macro above)
module imem_loader #(
   parameter int unsigned AW = 6,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW:0]   n_words,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic          we,
   output logic [AW-1:0] wa,
   output logic [DW-1:0] wd,
   output logic          cpu_hold,
   output logic          done,
   output logic [AW:0]   words_written,
   output logic [DW-1:0] checksum
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [AW:0] MAX_WORDS = {1'b1, {AW{1'b0}}};

   state_t        r_state;
   state_t        w_next;
   logic [AW:0]   r_target;
   logic [AW:0]   r_words;
   logic [1:0]    r_byte_cnt;
   logic [23:0]   r_shift;
   logic [AW-1:0] r_wa;
   logic [DW-1:0] r_wd;

   logic          w_accept;
   logic          w_start_ok;
   logic          w_last_word;
   logic [AW:0]   w_clamped;

   assign w_clamped   = (n_words > MAX_WORDS) ? MAX_WORDS : n_words;
   assign w_accept    = (r_state == S_LOAD) && in_valid;
   assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last_word = ((r_words + (AW+1)'(1)) == r_target);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and state-decoded outputs
   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      we       = 1'b0;
      cpu_hold = 1'b0;
      done     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            done = (r_state == S_DONE);
            if (start) begin
               w_next = (w_clamped == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            in_ready = 1'b1;
            cpu_hold = 1'b1;
            if (w_accept && (r_byte_cnt == 2'd3)) begin
               w_next = S_WRITE;
            end
         end
         S_WRITE: begin
            we       = 1'b1;
            cpu_hold = 1'b1;
            w_next   = w_last_word ? S_DONE : S_LOAD;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: byte assembly, address and word counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_target   <= '0;
         r_words    <= '0;
         r_byte_cnt <= '0;
         r_shift    <= '0;
         r_wa       <= '0;
         r_wd       <= '0;
      end else begin
         if (w_start_ok) begin
            r_target   <= w_clamped;
            r_words    <= '0;
            r_byte_cnt <= '0;
            r_wa       <= '0;
         end
         if (w_accept) begin
            r_shift    <= {r_shift[15:0], in_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            // Capture the full word as the 4th byte arrives so wd is
            // valid during the following WRITE cycle and held afterwards.
            if (r_byte_cnt == 2'd3) begin
               r_wd <= {r_shift, in_data};
            end
         end
         if (r_state == S_WRITE) begin
            r_wa    <= r_wa + 1'b1;
            r_words <= r_words + 1'b1;
         end
      end
   end

   assign wa            = r_wa;
   assign wd            = r_wd;
   assign words_written = r_words;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [DW-1:0] r_checksum;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_checksum <= '0;
      end else if (w_start_ok) begin
         r_checksum <= '0;
      end else if (r_state == S_WRITE) begin
         r_checksum <= r_checksum ^ r_wd;
      end
   end

   assign checksum = r_checksum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load jobs with expected
// word counts, randomized data and in_valid gaps, plus hand-written
// sequences for reset mid-load and start-while-busy.
module tb_imem_loader;

   localparam int AW = 6;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW:0]   n_words;
   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          we;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd;
   logic          cpu_hold;
   logic          done;
   logic [AW:0]   words_written;
   logic [DW-1:0] checksum;

   always #5 clk = ~clk;

   imem_loader #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .start(start), .n_words(n_words),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .we(we), .wa(wa), .wd(wd), .cpu_hold(cpu_hold), .done(done),
      .words_written(words_written), .checksum(checksum)
   );

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   typedef struct {
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      int unsigned   lat;
   } wr_t;

   typedef struct {
      logic [AW:0] n;
      int          kind;
      int          gap_mode;
      logic [AW:0] exp_ww;
   } vec_t;

   wr_t         obs_q[$];
   int unsigned cyc       = 0;
   int unsigned mon_bytes = 0;
   int unsigned last4     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Write/byte monitor; lat = cycles from 4th-byte acceptance to we
   always @(negedge clk) begin
      if (reset) begin
         mon_bytes <= 0;
      end else begin
         if (we) obs_q.push_back('{wa, wd, cyc - last4});
         if (in_valid && in_ready) begin
            mon_bytes <= mon_bytes + 1;
            if (mon_bytes % 4 == 3) last4 <= cyc;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int gap_of(input int mode);
      if (mode == 0) return 0;
      if (mode == 1) return 1;
      return int'($urandom_range(0, 2));
   endfunction

   function automatic logic [31:0] get_word(input int kind, input int unsigned i);
      case (kind)
         0: return i * 32'h1111_1111;
         1: return 32'(i);
         3: return 32'h1234_5678;
         4: return (i == 0) ? 32'hA5A5_A5A5 : 32'h0F0F_0F0F;
         default: return $urandom;
      endcase
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      in_valid = 1'b0;
      repeat (gap) tick();
      in_data  = b;
      in_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (in_ready) begin
            tick();
            in_valid = 1'b0;
            return;
         end
         tick();
      end
      n_total++;
      n_bad++;
      $display("FAIL byte_accept: got timeout expected in_ready");
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int mode);
      for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], gap_of(mode));
   endtask

   task automatic pulse_start(input logic [AW:0] n);
      n_words = n;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 30; k++) begin
         if (done) return;
         tick();
      end
   endtask

   task automatic run_job(input vec_t v);
      logic [31:0] sent[$];
      logic [31:0] csum;
      logic [31:0] w;
      int unsigned nw;
      bit          took;
      csum = '0;
      obs_q.delete();
      nw = (v.n > 7'd64) ? 64 : int'(v.n);
      pulse_start(v.n);
      check("csum_clear", 64'(checksum), 64'(0));
      if (nw == 0) begin
         check("zero_done", 64'(done), 64'(1));
         check("zero_hold", 64'(cpu_hold), 64'(0));
      end else begin
         check("busy_hold", 64'(cpu_hold), 64'(1));
         check("busy_done", 64'(done), 64'(0));
      end
      for (int unsigned i = 0; i < nw; i++) begin
         w = get_word(v.kind, i);
         sent.push_back(w);
         csum ^= w;
         send_word(w, v.gap_mode);
      end
      wait_done();
      check("done", 64'(done), 64'(1));
      check("hold_off", 64'(cpu_hold), 64'(0));
      check("ready_off", 64'(in_ready), 64'(0));
      check("words_written", 64'(words_written), 64'(v.exp_ww));
      check("write_count", 64'(obs_q.size()), 64'(nw));
      for (int i = 0; i < obs_q.size() && i < sent.size(); i++) begin
         check("wa", 64'(obs_q[i].wa), 64'(i));
         check("wd", 64'(obs_q[i].wd), 64'(sent[i]));
         check("we_latency", 64'(obs_q[i].lat), 64'(1));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      check("checksum", 64'(checksum), 64'(csum));
`else
      check("checksum", 64'(checksum), 64'(0));
`endif
      if (v.n > 7'd64) begin
         took     = 1'b0;
         in_data  = 8'h40;
         in_valid = 1'b1;
         repeat (6) begin
            @(negedge clk);
            if (in_ready) took = 1'b1;
            tick();
         end
         in_valid = 1'b0;
         check("extra_ready", 64'(took), 64'(0));
         check("extra_writes", 64'(obs_q.size()), 64'(64));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[8];
      vec_t one;
      vecs[0] = '{7'd4,   0, 0, 7'd4};
      vecs[1] = '{7'd1,   3, 1, 7'd1};
      vecs[2] = '{7'd0,   2, 0, 7'd0};
      vecs[3] = '{7'd100, 1, 0, 7'd64};
      vecs[4] = '{7'd2,   4, 2, 7'd2};
      vecs[5] = '{7'd7,   2, 2, 7'd7};
      vecs[6] = '{7'd64,  2, 0, 7'd64};
      vecs[7] = '{7'd127, 2, 2, 7'd64};

      reset    = 1'b1;
      start    = 1'b0;
      n_words  = '0;
      in_data  = '0;
      in_valid = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_we", 64'(we), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_hold", 64'(cpu_hold), 64'(0));
      reset = 1'b0;
      tick();

      for (int i = 0; i < 8; i++) run_job(vecs[i]);

      // Reset after two bytes of the second word
      obs_q.delete();
      pulse_start(7'd3);
      send_word(32'hCAFE_BABE, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_in_ready", 64'(in_ready), 64'(0));
      check("mid_rst_we", 64'(we), 64'(0));
      check("mid_rst_wa", 64'(wa), 64'(0));
      check("mid_rst_wd", 64'(wd), 64'(0));
      check("mid_rst_hold", 64'(cpu_hold), 64'(0));
      check("mid_rst_done", 64'(done), 64'(0));
      check("mid_rst_ww", 64'(words_written), 64'(0));
      check("mid_rst_csum", 64'(checksum), 64'(0));
      in_data  = 8'hEE;
      in_valid = 1'b1;
      repeat (4) tick();
      in_valid = 1'b0;
      check("mid_rst_writes", 64'(obs_q.size()), 64'(1));
      reset = 1'b0;
      tick();
      one = '{7'd1, 2, 2, 7'd1};
      run_job(one);

      // start pulses while busy are ignored
      obs_q.delete();
      pulse_start(7'd2);
      send_word(32'hDEAD_0001, 0);
      pulse_start(7'd0);
      check("busy_start_hold", 64'(cpu_hold), 64'(1));
      check("busy_start_done", 64'(done), 64'(0));
      send_byte(8'h55, 0);
      pulse_start(7'd5);
      send_byte(8'h66, 1);
      send_byte(8'h77, 0);
      send_byte(8'h88, 0);
      wait_done();
      check("busy_start_final", 64'(done), 64'(1));
      check("busy_start_ww", 64'(words_written), 64'(2));
      check("busy_start_count", 64'(obs_q.size()), 64'(2));
      if (obs_q.size() == 2) begin
         check("busy_start_wd", 64'(obs_q[1].wd), 64'(32'h5566_7788));
         check("busy_start_wa", 64'(obs_q[1].wa), 64'(1));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory: receives an 8-bit byte stream and assembles big-endian 32-bit instruction words.
- Drives a single-port write interface (we/wa/wd) into the 64-word instruction RAM at sequential addresses, replacing file-based preload.
- Sits between the host/debug byte source and imem; holds the CPU in reset (cpu_hold) while a program is being loaded.

Parameters:
- AW, 6, word-address width of instruction RAM (depth 2**AW = 64 words)
- DW, 32, instruction word width (fixed at 4 bytes; other values unsupported)

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse, begins a load of n_words words
- n_words  input  AW+1  word count latched on start; 0 means no load, values >64 clamp to 64
- in_data  input  8  stream byte, MSB byte of each word first
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte this cycle
- we  output  1  instruction RAM write enable, one-cycle pulse per word
- wa  output  AW  RAM word address
- wd  output  DW  RAM write data
- cpu_hold  output  1  high while busy; ORed into CPU reset at top level
- done  output  1  load finished, sticky until next start or reset
- words_written  output  AW+1  count of words written in current/last load
- checksum  output  DW  XOR of all written words (see Optional Feature)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and reset.
- Reset values: in_ready=0, we=0, wa=0, wd=0, cpu_hold=0, done=0, words_written=0, checksum=0; state=IDLE, byte counter=0, shift register=0.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE/DONE + start:
  - Latch target = min(n_words, 64) and clear words_written, byte counter, wa and checksum.
  - Clear done.
  - If target=0, go to DONE next cycle, so done rises one cycle after start; otherwise go to LOAD.
- start while in LOAD or WRITE is ignored.
- LOAD:
  - in_ready=1 and cpu_hold=1.
  - A byte is accepted when in_valid && in_ready: shift register <= {shift[23:0], in_data} and byte counter increments mod 4.
  - When the 4th byte is accepted, go to WRITE.
- WRITE (exactly one cycle):
  - in_ready=0, we=1, wd = assembled word, wa = current address, cpu_hold=1.
  - On exit, wa increments and words_written increments.
  - If words_written+1 == target, go to DONE; else go to LOAD.
- Latency: we asserts in the cycle immediately after the cycle in which the 4th byte is accepted. Peak throughput is 1 word per 5 cycles.
- wa wrap: with target=64, the final write is at wa=63. wa then wraps to 0 but no further write occurs.
- DONE: done=1, cpu_hold=0, in_ready=0. Bytes presented here are not consumed.
- Reset mid-load: the partial word is discarded, no write is issued, and all outputs return to reset values.
- in_valid low mid-word: the loader waits indefinitely and the partial word is retained.
- we is never asserted outside WRITE. wd and wa hold their last values when we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - checksum <= checksum ^ wd on each WRITE cycle.
  - Cleared on start and reset.
  - Valid when done=1.
- Undefined: checksum is tied to 0 and no checksum register is synthesised.

Test Plan:
- Reset, then start with n_words=4 and stream 00 00 00 00 11 11 11 11 22 22 22 22 33 33 33 33 with in_valid always high:
  - we pulses at wa=0..3 with wd=00000000, 11111111, 22222222, 33333333.
  - done=1, words_written=4, cpu_hold falls with done.
  - checksum=00000000 when enabled.
- Stream 12 34 56 78 with in_valid toggled every other cycle:
  - single write wd=12345678 at wa=0.
  - we asserts exactly one cycle after byte 78 is accepted.
- start with n_words=0:
  - done=1 one cycle after start, no we pulse, cpu_hold stays 0.
- start with n_words=100 and stream 64 words of value (index):
  - last write at wa=63, wd=0000003F, words_written=64.
  - the 65th word's bytes are not accepted (in_ready=0).
- Assert reset after 2 bytes of the 2nd word:
  - no further we; all outputs 0.
  - a new start with n_words=1 writes a fresh word at wa=0.
- With IMEM_LOADER_CHECKSUM_EN, load A5A5A5A5 and 0F0F0F0F:
  - checksum=AAAAAAAA.
  - without the macro, checksum=00000000 throughout.
